// File: rtl/vga_stream_pkg.sv
// Shared types and instruction-word layout for the QSPI video stream controller.
// A word is {colour, run length}; a run length of zero marks the end of the video.
package vga_stream_pkg;

  localparam int INSTR_W   = 18;
  localparam int COLOR_LSB = 12;
  localparam int RUN_W     = 12;
  localparam int COLOR_W   = 6;

  localparam logic [RUN_W-1:0] EOV_LEN = '0;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    END_WAIT = 2'd3
  } state_t;

  function automatic logic [COLOR_W-1:0] instr_color(input logic [INSTR_W-1:0] w);
    return w[COLOR_LSB +: COLOR_W];
  endfunction

  function automatic logic [RUN_W-1:0] instr_len(input logic [INSTR_W-1:0] w);
    return w[RUN_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry instruction prefetch FIFO; entry 0 is always the head.
// A push together with a pop at full shifts the tail forward and refills it.
module instr_fifo2
  import vga_stream_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;

  assign head = mem0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else               mem1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/qspi_stream_ctrl.sv
// Sequences the QSPI reader and expands its run-length words into pixel colour.
// HOLD: reader in reset | PRIME: fill FIFO | RUN: serve pixels | END_WAIT: marker seen, wait frame
module qspi_stream_ctrl #(
  parameter int RST_HOLD = 8,
  parameter int RUN_W    = 12,
  parameter int COLOR_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     qspi_rst_n,
  input  logic [RUN_W+COLOR_W-1:0] qspi_instr,
  input  logic                     qspi_valid,
  output logic                     qspi_shift,
  input  logic                     pixel_req,
  input  logic                     frame_start,
  output logic [COLOR_W-1:0]       pixel_rgb,
  output logic                     underrun,
  output logic                     loop_pulse
);

  import vga_stream_pkg::*;

  localparam int HCW = $clog2(RST_HOLD);

  state_t                   state;
  state_t                   state_nx;
  logic [HCW-1:0]           hold_cnt;
  logic                     armed;
  logic [COLOR_W-1:0]       color;
  logic [RUN_W-1:0]         rem;
  logic [RUN_W+COLOR_W-1:0] head;
  logic [1:0]               count;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic [RUN_W-1:0]         head_len;
  logic [COLOR_W-1:0]       head_color;

  assign head_len   = instr_len(head);
  assign head_color = instr_color(head);

  instr_fifo2 #(.W(RUN_W + COLOR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (qspi_instr),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    flush      = (state == HOLD);
    qspi_shift = (state != HOLD) && (count < 2'd2);
    case (state)
      HOLD:     if (hold_cnt == HCW'(RST_HOLD - 1)) state_nx = PRIME;
      PRIME:    if (frame_start && count != 2'd0) state_nx = RUN;
      RUN: begin
        if (pixel_req && rem == '0 && count != 2'd0) begin
          pop = 1'b1;
          if (head_len == EOV_LEN) state_nx = END_WAIT;
        end
      end
      END_WAIT: if (frame_start) state_nx = HOLD;
      default:  state_nx = HOLD;
    endcase
    // Armed gating makes a stalled, held-high valid count as a single word.
    push = qspi_valid && armed && (state == PRIME || state == RUN) &&
           (count < 2'd2 || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      armed      <= 1'b0;
      color      <= '0;
      rem        <= '0;
      pixel_rgb  <= '0;
      underrun   <= 1'b0;
      loop_pulse <= 1'b0;
      qspi_rst_n <= 1'b0;
    end else begin
      state      <= state_nx;
      qspi_rst_n <= (state_nx != HOLD);
      hold_cnt   <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      pixel_rgb  <= '0;
      loop_pulse <= 1'b0;

      if (state == HOLD)    armed <= 1'b0;
      else if (!qspi_valid) armed <= 1'b1;
      else if (push)        armed <= 1'b0;

      if (state == HOLD) begin
        rem   <= '0;
        color <= '0;
      end else if (state == RUN && pixel_req) begin
        if (rem != '0) begin
          pixel_rgb <= color;
          rem       <= rem - 1'b1;
        end else if (count == 2'd0) begin
          underrun <= 1'b1;
        end else if (head_len != EOV_LEN) begin
          color     <= head_color;
          pixel_rgb <= head_color;
          rem       <= head_len - 1'b1;
        end else begin
          loop_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_stream_ctrl.sv
// Self-checking bench for qspi_stream_ctrl: a behavioural flash reader feeds word lists,
// and expected pixels come from expanding each word into its run of colours.
module tb_qspi_stream_ctrl;
  import vga_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qspi_rst_n;
  logic [17:0] qspi_instr = '0;
  logic        qspi_valid = 1'b0;
  logic        qspi_shift;
  logic        pixel_req = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  pixel_rgb;
  logic        underrun;
  logic        loop_pulse;

  int errors = 0;
  int checks = 0;

  always #20 clk = ~clk;

  qspi_stream_ctrl #(.RST_HOLD(8), .RUN_W(12), .COLOR_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .qspi_rst_n  (qspi_rst_n),
    .qspi_instr  (qspi_instr),
    .qspi_valid  (qspi_valid),
    .qspi_shift  (qspi_shift),
    .pixel_req   (pixel_req),
    .frame_start (frame_start),
    .pixel_rgb   (pixel_rgb),
    .underrun    (underrun),
    .loop_pulse  (loop_pulse)
  );

  // Reader model: reader_n idle cycles per word, then valid held until shift accepts it.
  logic [17:0] words[$];
  int reader_n = 6;
  int ridx = 0;
  int rcnt = 6;
  bit hs = 1'b0;

  always @(negedge clk) begin
    if (qspi_rst_n !== 1'b1) begin
      ridx = 0; rcnt = reader_n; qspi_valid = 1'b0; hs = 1'b0;
    end else begin
      if (hs) begin
        qspi_valid = 1'b0; ridx++; rcnt = reader_n;
      end else if (!qspi_valid) begin
        rcnt--;
        if (rcnt <= 0) begin
          qspi_valid = 1'b1;
          qspi_instr = words[ridx % words.size()];
        end
      end
      hs = qspi_valid && qspi_shift;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; pixel_req = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    repeat (40) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic measure_hold(output int n, output bit shift_bad, output int fc);
    n = 0; shift_bad = 1'b0; fc = -1;
    while (qspi_rst_n === 1'b0 && n < 50) begin
      if (qspi_shift !== 1'b0) shift_bad = 1'b1;
      if (n == 2) fc = int'(dut.u_fifo.count);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n; bit bad; int fc;
    words = '{{6'h3F, 12'd3}};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (qspi_rst_n !== 1'b0) begin errors++; $display("FAIL reset_qspi_rst_n got %b expected 0", qspi_rst_n); end
    checks++; if (qspi_shift !== 1'b0) begin errors++; $display("FAIL reset_shift got %b expected 0", qspi_shift); end
    checks++; if (pixel_rgb !== 6'h00) begin errors++; $display("FAIL reset_rgb got %h expected 00", pixel_rgb); end
    checks++; if (underrun !== 1'b0 || loop_pulse !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b expected 00", underrun, loop_pulse); end
    checks++; if (dut.u_fifo.count !== 2'd0 || dut.rem !== 12'd0 || dut.armed !== 1'b0) begin errors++; $display("FAIL reset_internal count=%0d rem=%0d armed=%b expected 0 0 0", dut.u_fifo.count, dut.rem, dut.armed); end
    rst_n = 1'b1;
    measure_hold(n, bad, fc);
    checks++; if (n != 8) begin errors++; $display("FAIL reset_hold_len got %0d expected 8", n); end
    checks++; if (bad) begin errors++; $display("FAIL reset_hold_shift got 1 expected 0"); end
  endtask

  task automatic test_basic_and_loop();
    logic [5:0] exp5 [5];
    int n; bit bad; int fc;
    exp5 = '{6'h3F, 6'h3F, 6'h3F, 6'h05, 6'h05};
    words = '{{6'h3F, 12'd3}, {6'h05, 12'd2}, {6'h2A, 12'd0}};
    do_reset();
    start_run();
    pixel_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (pixel_rgb !== exp5[i] || underrun !== 1'b0) begin errors++; $display("FAIL basic_rgb[%0d] got %h/%b expected %h/0", i, pixel_rgb, underrun, exp5[i]); end
    end
    @(negedge clk);
    checks++; if (pixel_rgb !== 6'h00 || loop_pulse !== 1'b1) begin errors++; $display("FAIL marker got rgb=%h loop=%b expected 00/1", pixel_rgb, loop_pulse); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (pixel_rgb !== 6'h00 || loop_pulse !== 1'b0) begin errors++; $display("FAIL end_wait[%0d] got rgb=%h loop=%b expected 00/0", i, pixel_rgb, loop_pulse); end
    end
    pixel_req = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    measure_hold(n, bad, fc);
    checks++; if (n != 8) begin errors++; $display("FAIL loop_hold_len got %0d expected 8", n); end
    checks++; if (fc != 0 || bad) begin errors++; $display("FAIL loop_fifo_flush got count=%0d shift_bad=%b expected 0/0", fc, bad); end
  endtask

  task automatic test_stall();
    logic [5:0] exp4 [4];
    exp4 = '{6'h11, 6'h22, 6'h33, 6'h00};
    words = '{{6'h11, 12'd1}, {6'h22, 12'd1}, {6'h33, 12'd1}, {6'h2A, 12'd0}};
    do_reset();
    start_run();
    repeat (30) @(negedge clk);
    checks++; if (dut.u_fifo.count !== 2'd2 || qspi_valid !== 1'b1) begin errors++; $display("FAIL stall_full got count=%0d valid=%b expected 2/1", dut.u_fifo.count, qspi_valid); end
    for (int i = 0; i < 4; i++) begin
      pixel_req = 1'b1;
      @(negedge clk);
      pixel_req = 1'b0;
      checks++; if (pixel_rgb !== exp4[i] || loop_pulse !== (i == 3)) begin errors++; $display("FAIL stall_rgb[%0d] got %h/%b expected %h/%b", i, pixel_rgb, loop_pulse, exp4[i], i == 3); end
      if (i == 0) begin
        checks++; if (dut.u_fifo.count !== 2'd2) begin errors++; $display("FAIL stall_push got count=%0d expected 2", dut.u_fifo.count); end
      end
      repeat (10) @(negedge clk);
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL stall_underrun got %b expected 0", underrun); end
  endtask

  task automatic test_underrun();
    logic [5:0] exp4 [4];
    exp4 = '{6'h01, 6'h02, 6'h03, 6'h00};
    words = '{{6'h01, 12'd1}, {6'h02, 12'd1}, {6'h03, 12'd1}, {6'h04, 12'd1}, {6'h05, 12'd1}};
    do_reset();
    start_run();
    pixel_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (pixel_rgb !== exp4[i] || underrun !== (i == 3)) begin errors++; $display("FAIL underrun_seq[%0d] got %h/%b expected %h/%b", i, pixel_rgb, underrun, exp4[i], i == 3); end
    end
    repeat (20) @(negedge clk);
    pixel_req = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b expected 1", underrun); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b expected 0", underrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_mid_reset();
    words = '{{6'h15, 12'd200}};
    do_reset();
    start_run();
    pixel_req = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (pixel_rgb !== 6'h15 || dut.rem !== 12'd100) begin errors++; $display("FAIL midrun got rgb=%h rem=%0d expected 15/100", pixel_rgb, dut.rem); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== HOLD || dut.hold_cnt !== '0) begin errors++; $display("FAIL midreset_state got %0d/%0d expected HOLD/0", dut.state, dut.hold_cnt); end
    checks++; if (dut.rem !== 12'd0 || pixel_rgb !== 6'h00 || underrun !== 1'b0) begin errors++; $display("FAIL midreset_regs got rem=%0d rgb=%h und=%b expected 0/00/0", dut.rem, pixel_rgb, underrun); end
    rst_n = 1'b1;
    pixel_req = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] exp[$];
    logic [6:0] e;
    logic [5:0] c;
    int nw, len, cyc, n, fc;
    bit r, done, bad;
    words = {};
    exp = {};
    nw = $urandom_range(6, 10);
    for (int i = 0; i < nw; i++) begin
      c = 6'($urandom_range(1, 63));
      len = $urandom_range(4, 10);
      words.push_back({c, 12'(len)});
      for (int k = 0; k < len; k++) exp.push_back({1'b0, c});
    end
    words.push_back({6'($urandom_range(1, 63)), 12'd0});
    exp.push_back(7'h40);
    reader_n = 2;
    do_reset();
    start_run();
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      r = 1'($urandom % 2);
      pixel_req = r;
      frame_start = ($urandom % 16) == 0;
      @(negedge clk);
      cyc++;
      e = (r && exp.size() > 0) ? exp.pop_front() : 7'h00;
      checks++; if (pixel_rgb !== e[5:0] || loop_pulse !== e[6]) begin errors++; $display("FAIL random_pix cyc=%0d got %h/%b expected %h/%b", cyc, pixel_rgb, loop_pulse, e[5:0], e[6]); end
      if (e[6]) done = 1'b1;
    end
    frame_start = 1'b0;
    pixel_req = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL random_timeout got no marker expected marker within 3000 cycles"); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL random_underrun got %b expected 0", underrun); end
    pixel_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pixel_rgb !== 6'h00) begin errors++; $display("FAIL random_end_wait got %h expected 00", pixel_rgb); end
    pixel_req = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    measure_hold(n, bad, fc);
    checks++; if (n != 8 || fc != 0) begin errors++; $display("FAIL random_restart got hold=%0d count=%0d expected 8/0", n, fc); end
    reader_n = 6;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_and_loop();
    test_stall();
    test_underrun();
    test_mid_reset();
    for (int t = 0; t < 3; t++) test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
